// File: rtl/smpl_window_queue_if.sv
// Sample-queue bus: write strobe, sample and flush toward the queue; burst readout and status back.
interface smpl_window_queue_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 1536
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             wrt_smpl;
    logic [WIDTH-1:0] new_smpl;
    logic             flush;
    logic [WIDTH-1:0] smpl_out;
    logic             smpl_vld;
    logic             seq_start;
    logic             seq_done;
    logic             full;
    logic [CNT_W-1:0] fill_cnt;
    logic             overrun;

    modport master (
        output wrt_smpl, new_smpl, flush,
        input  smpl_out, smpl_vld, seq_start, seq_done, full, fill_cnt, overrun
    );

    modport slave (
        input  wrt_smpl, new_smpl, flush,
        output smpl_out, smpl_vld, seq_start, seq_done, full, fill_cnt, overrun
    );
endinterface

// File: rtl/smpl_window_queue.sv
// Circular sample store; each accepted sample once full triggers a burst of the oldest RD_LEN samples.
// Define SMPL_QUEUE_OVERRUN_EN to build the sticky overrun flag for samples dropped during a burst.
module smpl_window_queue #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 1536,
    parameter int RD_LEN = 1021
) (
    input logic                clk,
    input logic                rst,
    smpl_window_queue_if.slave bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

    typedef enum logic [1:0] {S_FILL, S_FULL, S_READOUT} state_t;

    // Compare-and-wrap so DEPTH need not be a power of two.
    function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
        return (p == ADDR_W'(DEPTH - 1)) ? '0 : p + ADDR_W'(1);
    endfunction

    state_t                  state, state_nxt;
    logic signed [WIDTH-1:0] ram [DEPTH];
    logic [ADDR_W-1:0]       wr_ptr, old_ptr, rd_ptr_p0;
    logic [CNT_W-1:0]        fill_cnt, rd_cnt_p0;
    logic                    full, wr_en, trig, rd_en_p0;
    logic signed [WIDTH-1:0] smpl_p1;
    logic                    vld_p1, start_p1, done_p1;

    always_ff @(posedge clk) begin
        if (rst) state <= S_FILL;
        else     state <= state_nxt;
    end

    // READOUT spans RD_LEN read cycles plus one drain cycle while the last read data is presented.
    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        trig      = 1'b0;
        rd_en_p0  = 1'b0;
        if (bus.flush) begin
            state_nxt = S_FILL;
        end else begin
            case (state)
                S_FILL: begin
                    if (bus.wrt_smpl) begin
                        wr_en = 1'b1;
                        if (fill_cnt == CNT_W'(DEPTH - 1)) begin
                            trig      = 1'b1;
                            state_nxt = S_READOUT;
                        end
                    end
                end
                S_FULL: begin
                    if (bus.wrt_smpl) begin
                        wr_en     = 1'b1;
                        trig      = 1'b1;
                        state_nxt = S_READOUT;
                    end
                end
                S_READOUT: begin
                    if (rd_cnt_p0 != '0) rd_en_p0 = 1'b1;
                    else                 state_nxt = S_FULL;
                end
                default: state_nxt = S_FILL;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) ram[wr_ptr] <= bus.new_smpl;
    end

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            wr_ptr   <= '0;
            old_ptr  <= '0;
            fill_cnt <= '0;
            full     <= 1'b0;
        end else if (wr_en) begin
            wr_ptr <= ptr_inc(wr_ptr);
            if (state == S_FULL) begin
                old_ptr <= ptr_inc(old_ptr);
            end else begin
                fill_cnt <= fill_cnt + CNT_W'(1);
                full     <= trig;
            end
        end
    end

    // Stage p0: read address and burst down-counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_p0 <= '0;
            rd_cnt_p0 <= '0;
        end else if (trig) begin
            rd_ptr_p0 <= (state == S_FULL) ? ptr_inc(old_ptr) : old_ptr;
            rd_cnt_p0 <= CNT_W'(RD_LEN);
        end else if (rd_en_p0) begin
            rd_ptr_p0 <= ptr_inc(rd_ptr_p0);
            rd_cnt_p0 <= rd_cnt_p0 - CNT_W'(1);
        end
    end

    // Stage p1: registered RAM data with its valid and burst markers.
    always_ff @(posedge clk) begin
        if (rst) smpl_p1 <= '0;
        else if (rd_en_p0) smpl_p1 <= ram[rd_ptr_p0];
    end

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            vld_p1   <= 1'b0;
            start_p1 <= 1'b0;
            done_p1  <= 1'b0;
        end else begin
            vld_p1   <= rd_en_p0;
            start_p1 <= rd_en_p0 && (rd_cnt_p0 == CNT_W'(RD_LEN));
            done_p1  <= rd_en_p0 && (rd_cnt_p0 == CNT_W'(1));
        end
    end

`ifdef SMPL_QUEUE_OVERRUN_EN
    logic overrun;
    always_ff @(posedge clk) begin
        if (rst || bus.flush) overrun <= 1'b0;
        else if (state == S_READOUT && bus.wrt_smpl) overrun <= 1'b1;
    end
    assign bus.overrun = overrun;
`else
    assign bus.overrun = 1'b0;
`endif

    assign bus.smpl_out  = smpl_p1;
    assign bus.smpl_vld  = vld_p1;
    assign bus.seq_start = start_p1;
    assign bus.seq_done  = done_p1;
    assign bus.full      = full;
    assign bus.fill_cnt  = fill_cnt;
endmodule
